// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch squashes, multicycle EX holds (HAZ_PERF_EN adds stall/flush counters).
// Latency: outputs are combinational from state, cnt and inputs; a multicycle op holds EX for MC_LAT-1 cycles, then mc_done pulses.
// Backpressure: stalls the front end through pc_we/if_id_we and freezes ID/EX and EX/MEM through ex_hold.
module hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int RA_W   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_mc_start,
  input  logic            branch_taken,
`ifdef HAZ_PERF_EN
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt,
`endif
  output logic            pc_we,
  output logic            if_id_we,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            ex_hold,
  output logic            mc_done
);

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       load_use;

  // x0 is hardwired to zero, so a load targeting it can never create a dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_hold     = 1'b0;
    mc_done     = 1'b0;
    state_n     = state;
    cnt_n       = cnt;
    if (!rst) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ex_mc_start) begin
            ex_hold  = 1'b1;
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            cnt_n    = 8'(MC_LAT - 2);
            state_n  = MC_WAIT;
          end else if (load_use) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        MC_WAIT: begin
          // EX is occupied by the mc op, so branch/load/start inputs are meaningless here.
          if (cnt != 8'd0) begin
            ex_hold  = 1'b1;
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            cnt_n    = cnt - 8'd1;
          end else begin
            mc_done = 1'b1;
            state_n = RUN;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (id_ex_flush && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table on an MC_LAT=4 instance plus hand sequences for MC_LAT=2 and the perf counters.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic       ex_mem_read = 1'b0, ex_mc_start = 1'b0, branch_taken = 1'b0;

  logic pc_we4, if_id_we4, if_id_flush4, id_ex_flush4, ex_hold4, mc_done4;
  logic pc_we2, if_id_we2, if_id_flush2, id_ex_flush2, ex_hold2, mc_done2;
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt4, flush_cnt4, stall_cnt2, flush_cnt2;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_LAT(4), .RA_W(5)) dut4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mc_start(ex_mc_start), .branch_taken(branch_taken),
`ifdef HAZ_PERF_EN
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4),
`endif
    .pc_we(pc_we4), .if_id_we(if_id_we4), .if_id_flush(if_id_flush4),
    .id_ex_flush(id_ex_flush4), .ex_hold(ex_hold4), .mc_done(mc_done4)
  );

  hazard_ctrl #(.MC_LAT(2), .RA_W(5)) dut2 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mc_start(ex_mc_start), .branch_taken(branch_taken),
`ifdef HAZ_PERF_EN
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2),
`endif
    .pc_we(pc_we2), .if_id_we(if_id_we2), .if_id_flush(if_id_flush2),
    .id_ex_flush(id_ex_flush2), .ex_hold(ex_hold2), .mc_done(mc_done2)
  );

  // Expected output bundle: {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_hold, mc_done}
  localparam logic [5:0] DEF = 6'b110000;
  localparam logic [5:0] STL = 6'b000100;
  localparam logic [5:0] BRF = 6'b111100;
  localparam logic [5:0] HLD = 6'b000010;
  localparam logic [5:0] DON = 6'b110001;
  localparam logic [5:0] RSO = 6'b001100;

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, mc, br;
    logic [5:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vt[23];

  function automatic vec_t mk(logic r, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                              logic [4:0] rd, logic mr, logic mc, logic br, logic [5:0] exp);
    vec_t v;
    v.rst = r; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.rd = rd; v.mr = mr; v.mc = mc; v.br = br; v.exp = exp;
    return v;
  endfunction

  task automatic drive(vec_t v);
    rst = v.rst; id_rs1 = v.rs1; id_rs1_used = v.u1; id_rs2 = v.rs2; id_rs2_used = v.u2;
    ex_rd = v.rd; ex_mem_read = v.mr; ex_mc_start = v.mc; branch_taken = v.br;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] o4();
    return {pc_we4, if_id_we4, if_id_flush4, id_ex_flush4, ex_hold4, mc_done4};
  endfunction

  function automatic logic [5:0] o2();
    return {pc_we2, if_id_we2, if_id_flush2, id_ex_flush2, ex_hold2, mc_done2};
  endfunction

  // Drive mid-low-phase, sample 2ns later, well away from the posedge.
  task automatic step(vec_t v);
    @(negedge clk);
    drive(v);
    #2;
  endtask

  vec_t idle, rstv, mcv;

  initial begin
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF);
    rstv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RSO);
    mcv  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, HLD);

    vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, RSO);   // reset with mc_start high
    vt[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, RSO);
    vt[2]  = idle;
    vt[3]  = mk(1, 0, 0, 7, 1, 7, 1, 0, 0, STL);   // load-use on rs2
    vt[4]  = idle;
    vt[5]  = mk(1, 3, 1, 0, 0, 3, 1, 0, 0, STL);   // load-use on rs1
    vt[6]  = mk(1, 3, 0, 0, 0, 3, 1, 0, 0, DEF);   // rs1 matches but unused
    vt[7]  = mk(1, 0, 0, 0, 1, 0, 1, 0, 0, DEF);   // x0 never hazards
    vt[8]  = mk(1, 0, 0, 7, 1, 7, 0, 0, 0, DEF);   // not a load
    vt[9]  = mk(1, 0, 0, 7, 1, 7, 1, 0, 1, BRF);   // branch beats load-use
    vt[10] = idle;
    vt[11] = mcv;                                  // T
    vt[12] = mcv;                                  // T+1
    vt[13] = mcv;                                  // T+2
    vt[14] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, DON);   // T+3, start still high
    vt[15] = idle;
    vt[16] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, BRF);   // branch beats mc_start
    vt[17] = idle;
    vt[18] = mk(1, 0, 0, 7, 1, 7, 1, 1, 0, HLD);   // mc + load both high: mc wins
    vt[19] = mk(1, 0, 0, 7, 1, 7, 1, 0, 1, HLD);   // branch/load ignored in MC_WAIT
    vt[20] = mk(1, 0, 0, 7, 1, 7, 1, 0, 0, HLD);
    vt[21] = mk(1, 0, 0, 7, 1, 7, 1, 1, 1, DON);
    vt[22] = idle;

    for (int i = 0; i < 23; i++) begin
      step(vt[i]);
      chk($sformatf("vec%0d", i), 32'(o4()), 32'(vt[i].exp));
    end

    // MC_LAT=2: one hold cycle then mc_done; then reset aborts a fresh op.
    step(rstv); chk("m2_rst", 32'(o2()), 32'(RSO));
    step(mcv);  chk("m2_T", 32'(o2()), 32'(HLD));
    step(mcv);  chk("m2_T1_done", 32'(o2()), 32'(DON));
    step(idle); chk("m2_idle", 32'(o2()), 32'(DEF));
    step(mcv);  chk("m2_op2_T", 32'(o2()), 32'(HLD));
    step(rstv); chk("m2_abort", 32'(o2()), 32'(RSO));
    step(idle); chk("m2_after_abort", 32'(o2()), 32'(DEF));
    step(idle); chk("m2_still_run", 32'(o2()), 32'(DEF));

    // Reset mid-op on MC_LAT=4: pipeline restarts clean without a stray mc_done.
    step(rstv);
    step(mcv);  chk("m4_T", 32'(o4()), 32'(HLD));
    step(mcv);  chk("m4_T1", 32'(o4()), 32'(HLD));
    step(rstv); chk("m4_abort", 32'(o4()), 32'(RSO));
    step(idle); chk("m4_after_abort", 32'(o4()), 32'(DEF));
    step(idle); chk("m4_no_done", 32'(o4()), 32'(DEF));

    // Perf scenario: 1 load-use, 1 branch, 1 MC_LAT=4 op.
    step(rstv);
    step(vt[3]);  chk("pf_lu", 32'(o4()), 32'(STL));
    step(idle);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, BRF)); chk("pf_br", 32'(o4()), 32'(BRF));
    step(idle);
    step(mcv); step(mcv); step(mcv);
    step(idle); chk("pf_done", 32'(o4()), 32'(DON));
    step(idle);
    step(idle);
`ifdef HAZ_PERF_EN
    chk("stall_cnt", stall_cnt4, 32'd4);
    chk("flush_cnt", flush_cnt4, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
